battle_datapath: RTL and testbench

Datapath for the Pokémon battle controller. It holds both Pokémon's HP, latches the player's and AI's moves, and computes damage with a multi-cycle shift-add multiplier. It applies damage to the selected target exactly once per calculation. It consumes the controller's `ld_move`, `calc_damage`, `active_trainer`, `target` and `apply_damage`, and returns `hp_is_zero`.

---
 rtl/battle_datapath_if.sv | 28 ++
 rtl/battle_datapath.sv | 139 +++++++++++++
 tb/tb_battle_datapath.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/battle_datapath_if.sv
// Controller <-> battle datapath bundle: move/damage commands in, HP and damage status out.
interface battle_datapath_if;
   logic       ld_move;
   logic [1:0] move_sel;
   logic       calc_damage;
   logic       active_trainer;
   logic       target;
   logic       apply_damage;
   logic [1:0] p_move;
   logic [1:0] ai_move;
   logic [7:0] p_hp;
   logic [7:0] ai_hp;
   logic [7:0] damage;
   logic       dmg_valid;
   logic       hp_is_zero;

   // Controller side drives commands and observes status.
   modport master (
      output ld_move, move_sel, calc_damage, active_trainer, target, apply_damage,
      input  p_move, ai_move, p_hp, ai_hp, damage, dmg_valid, hp_is_zero
   );

   // Datapath side consumes commands and reports status.
   modport slave (
      input  ld_move, move_sel, calc_damage, active_trainer, target, apply_damage,
      output p_move, ai_move, p_hp, ai_hp, damage, dmg_valid, hp_is_zero
   );
endinterface

// File: rtl/battle_datapath.sv
// Battle datapath: HP registers, move latches, LFSR-driven AI move and a 3-cycle
// shift-add damage multiplier whose result is applied to one HP register once per calculation.
module battle_datapath #(
   parameter logic [7:0] HP_INIT = 8'd100,
   parameter logic [2:0] ATK_P   = 3'd5,
   parameter logic [2:0] ATK_AI  = 3'd4
) (
   input logic               clk,
   input logic               reset_n,
   battle_datapath_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

   state_e     state_q, state_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [1:0] p_move_q, p_move_d;
   logic [1:0] ai_move_q, ai_move_d;
   logic [7:0] p_hp_q, p_hp_d;
   logic [7:0] ai_hp_q, ai_hp_d;
   logic [7:0] damage_q, damage_d;
   logic       dmg_valid_q, dmg_valid_d;
   logic       attacker_q, attacker_d;
   logic [7:0] acc_q, acc_d;
   logic [1:0] cnt_q, cnt_d;

   logic [1:0] atk_move;
   logic [4:0] power;
   logic [2:0] atk;
   logic [7:0] partial;
   logic [7:0] acc_next;
   logic [7:0] tgt_hp;
   logic [7:0] tgt_hp_new;

   // Operand selection and one multiplier step; moves are read live during MUL.
   always_comb begin
      atk_move   = attacker_q ? ai_move_q : p_move_q;
      power      = 5'd8 + {1'b0, atk_move, 2'b00};
      atk        = attacker_q ? ATK_AI : ATK_P;
      partial    = atk[cnt_q] ? ({3'b000, power} << cnt_q) : 8'd0;
      acc_next   = acc_q + partial;
      tgt_hp     = bus.target ? ai_hp_q : p_hp_q;
      tgt_hp_new = (tgt_hp > damage_q) ? (tgt_hp - damage_q) : 8'd0;
   end

   // Next-state logic for the LFSR, move latches and the damage engine.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      p_move_d    = p_move_q;
      ai_move_d   = ai_move_q;
      p_hp_d      = p_hp_q;
      ai_hp_d     = ai_hp_q;
      damage_d    = damage_q;
      dmg_valid_d = dmg_valid_q;
      attacker_d  = attacker_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;

      if (bus.ld_move) begin
         p_move_d  = bus.move_sel;
         ai_move_d = lfsr_q[1:0];
      end

      unique case (state_q)
         StIdle: begin
            if (bus.calc_damage) begin
               attacker_d = bus.active_trainer;
               acc_d      = 8'd0;
               cnt_d      = 2'd0;
               state_d    = StMul;
            end
         end
         StMul: begin
            acc_d = acc_next;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd2) begin
               damage_d    = acc_next >> 2;
               dmg_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone: begin
            if (bus.apply_damage) begin
               // Leaving DONE right away is what guarantees a single application.
               if (bus.target) ai_hp_d = tgt_hp_new;
               else            p_hp_d  = tgt_hp_new;
               dmg_valid_d = 1'b0;
               state_d     = StIdle;
            end else if (bus.calc_damage && (bus.active_trainer != attacker_q)) begin
               attacker_d  = bus.active_trainer;
               acc_d       = 8'd0;
               cnt_d       = 2'd0;
               dmg_valid_d = 1'b0;
               state_d     = StMul;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         lfsr_q      <= 8'hA5;
         p_move_q    <= 2'd0;
         ai_move_q   <= 2'd0;
         p_hp_q      <= HP_INIT;
         ai_hp_q     <= HP_INIT;
         damage_q    <= 8'd0;
         dmg_valid_q <= 1'b0;
         attacker_q  <= 1'b0;
         acc_q       <= 8'd0;
         cnt_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         p_move_q    <= p_move_d;
         ai_move_q   <= ai_move_d;
         p_hp_q      <= p_hp_d;
         ai_hp_q     <= ai_hp_d;
         damage_q    <= damage_d;
         dmg_valid_q <= dmg_valid_d;
         attacker_q  <= attacker_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.p_move     = p_move_q;
   assign bus.ai_move    = ai_move_q;
   assign bus.p_hp       = p_hp_q;
   assign bus.ai_hp      = ai_hp_q;
   assign bus.damage     = damage_q;
   assign bus.dmg_valid  = dmg_valid_q;
   assign bus.hp_is_zero = bus.target ? (ai_hp_q == 8'd0) : (p_hp_q == 8'd0);

endmodule

// File: tb/tb_battle_datapath.sv
// Bench for battle_datapath: directed stimulus pushes expected damage/latency into a queue,
// a negedge monitor pops and checks whenever dmg_valid rises.
module tb_battle_datapath;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   logic prev_valid = 1'b0;

   typedef struct {
      logic [7:0] dmg;
      int         cyc;
   } exp_t;
   exp_t exp_q[$];

   battle_datapath_if bus ();

   battle_datapath #(
      .HP_INIT (8'd100),
      .ATK_P   (3'd5),
      .ATK_AI  (3'd4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every rising dmg_valid must match the oldest expectation.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus.dmg_valid === 1'b1 && prev_valid === 1'b0) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_dmg_valid: got damage %0d at cycle %0d, expected none",
                     bus.damage, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("damage", {24'd0, bus.damage}, {24'd0, e.dmg});
            check("dmg_latency", cyc, e.cyc);
         end
      end
      prev_valid <= bus.dmg_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_calc(input logic who, input logic tgt, input logic [7:0] dmg,
                             input bit push);
      bus.active_trainer = who;
      bus.target         = tgt;
      bus.calc_damage    = 1'b1;
      if (push) exp_q.push_back('{dmg: dmg, cyc: cyc + 4});
   endtask

   task automatic wait_valid();
      int n = 0;
      while (bus.dmg_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check("dmg_valid_wait", {31'd0, bus.dmg_valid}, 32'd1);
      bus.calc_damage = 1'b0;
   endtask

   task automatic apply(input logic tgt, input int cycles);
      bus.target       = tgt;
      bus.apply_damage = 1'b1;
      repeat (cycles) tick();
      bus.apply_damage = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] hp_seq [5];
      hp_seq = '{8'd75, 8'd50, 8'd25, 8'd0, 8'd0};

      reset_n            = 1'b0;
      bus.ld_move        = 1'b0;
      bus.move_sel       = 2'd0;
      bus.calc_damage    = 1'b0;
      bus.active_trainer = 1'b0;
      bus.target         = 1'b0;
      bus.apply_damage   = 1'b0;
      tick();
      tick();
      check("rst_p_hp", {24'd0, bus.p_hp}, 32'd100);
      check("rst_ai_hp", {24'd0, bus.ai_hp}, 32'd100);
      check("rst_dmg_valid", {31'd0, bus.dmg_valid}, 32'd0);
      check("rst_hp_is_zero", {31'd0, bus.hp_is_zero}, 32'd0);
      check("rst_ai_move", {30'd0, bus.ai_move}, 32'd0);
      check("rst_damage", {24'd0, bus.damage}, 32'd0);

      // First cycle out of reset: LFSR = A5, so the AI move is 2'b01.
      reset_n      = 1'b1;
      bus.ld_move  = 1'b1;
      bus.move_sel = 2'd3;
      tick();
      bus.ld_move = 1'b0;
      check("latch_p_move", {30'd0, bus.p_move}, 32'd3);
      check("latch_ai_move", {30'd0, bus.ai_move}, 32'd1);

      apply(1'b1, 2);
      check("idle_apply_ignored", {24'd0, bus.ai_hp}, 32'd100);

      // Player attack: power 20 * atk 5 = 100, >>2 = 25; apply held 5 cycles.
      for (int i = 0; i < 5; i++) begin
         start_calc(1'b0, 1'b1, 8'd25, 1'b1);
         wait_valid();
         apply(1'b1, 5);
         check($sformatf("ai_hp_after_hit%0d", i), {24'd0, bus.ai_hp}, {24'd0, hp_seq[i]});
         check("dmg_valid_cleared", {31'd0, bus.dmg_valid}, 32'd0);
      end
      bus.target = 1'b1;
      #1;
      check("hp_is_zero_ai", {31'd0, bus.hp_is_zero}, 32'd1);
      check("p_hp_untouched", {24'd0, bus.p_hp}, 32'd100);
      bus.target = 1'b0;
      #1;
      check("hp_is_zero_player", {31'd0, bus.hp_is_zero}, 32'd0);

      // Attacker restart from DONE: AI move 1 -> power 12 * atk 4 = 48, >>2 = 12.
      start_calc(1'b0, 1'b1, 8'd25, 1'b1);
      wait_valid();
      bus.calc_damage    = 1'b1;
      bus.active_trainer = 1'b1;
      exp_q.push_back('{dmg: 8'd12, cyc: cyc + 4});
      tick();
      bus.calc_damage = 1'b0;
      check("restart_valid_drop", {31'd0, bus.dmg_valid}, 32'd0);
      wait_valid();
      apply(1'b0, 3);
      check("p_hp_after_ai_hit", {24'd0, bus.p_hp}, 32'd88);
      check("ai_hp_still_zero", {24'd0, bus.ai_hp}, 32'd0);

      // Reset in the middle of MUL.
      start_calc(1'b0, 1'b1, 8'd0, 1'b0);
      tick();
      tick();
      reset_n         = 1'b0;
      bus.calc_damage = 1'b0;
      tick();
      check("midrst_damage", {24'd0, bus.damage}, 32'd0);
      check("midrst_dmg_valid", {31'd0, bus.dmg_valid}, 32'd0);
      check("midrst_p_hp", {24'd0, bus.p_hp}, 32'd100);
      check("midrst_ai_hp", {24'd0, bus.ai_hp}, 32'd100);
      check("midrst_p_move", {30'd0, bus.p_move}, 32'd0);
      reset_n = 1'b1;
      repeat (5) tick();
      check("midrst_engine_idle", {31'd0, bus.dmg_valid}, 32'd0);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
